fmdll_mode_seq: RTL and testbench

Mode and divide-ratio sequencer for the FMDLL hold-control path. It generates the `M` mode select and the `DIV_M` period pulse that the hold-control stage consumes. It accepts a new mode/ratio configuration through a valid/ready handshake. New settings apply only on a period boundary and are followed by a fixed settle window, so the hold-control stage never sees a truncated or glitched divide period.

---
 rtl/fmdll_mode_seq_if.sv | 9 +
 rtl/fmdll_mode_seq.sv | 74 +++++++
 tb/tb_fmdll_mode_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fmdll_mode_seq_if.sv
// fmdll_mode_seq_if: configuration request handshake between the mode requester and the sequencer
interface fmdll_mode_seq_if #(parameter int DIV_W = 4);
    logic             valid;
    logic             m;
    logic [DIV_W-1:0] div;
    logic             ready;
    modport master (output valid, output m, output div, input ready);
    modport slave (input valid, input m, input div, output ready);
endinterface

// File: rtl/fmdll_mode_seq.sv
// fmdll_mode_seq: M / DIV_M sequencer that swaps config only on a period boundary, then settles
module fmdll_mode_seq #(
    parameter int DIV_W  = 4,
    parameter int SETTLE = 8
) (
    input  logic             clk,
    input  logic             rst,
    fmdll_mode_seq_if.slave  cfg,
    output logic             M,
    output logic             DIV_M,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy
);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SETTLE} state_t;
    state_t           state, state_n;
    logic             m_n, pend_m, pend_m_n, div_m_n, wrap;
    logic [DIV_W-1:0] div_n, pend_div, pend_div_n, cnt, cnt_n;
    logic [SW-1:0]    scnt, scnt_n;
    assign cfg.ready = state == ST_RUN;
    assign busy      = state != ST_RUN;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_SETTLE;
            M        <= 1'b1;
            cur_div  <= DIV_W'(2);
            cnt      <= '0;
            scnt     <= '0;
            DIV_M    <= 1'b0;
            pend_m   <= 1'b1;
            pend_div <= DIV_W'(2);
        end else begin
            state    <= state_n;
            M        <= m_n;
            cur_div  <= div_n;
            cnt      <= cnt_n;
            scnt     <= scnt_n;
            DIV_M    <= div_m_n;
            pend_m   <= pend_m_n;
            pend_div <= pend_div_n;
        end
    end
    always_comb begin
        state_n    = state;
        m_n        = M;
        div_n      = cur_div;
        cnt_n      = cnt;
        scnt_n     = scnt;
        pend_m_n   = pend_m;
        pend_div_n = pend_div;
        wrap       = cnt == cur_div - DIV_W'(1);
        if (state == ST_SETTLE) begin
            if (scnt == SW'(SETTLE - 1)) state_n = ST_RUN;
            else scnt_n = scnt + SW'(1);
        end else begin
            cnt_n = wrap ? '0 : cnt + DIV_W'(1);
            if (state == ST_RUN && cfg.valid) begin
                pend_m_n   = cfg.m;
                pend_div_n = cfg.div < DIV_W'(2) ? DIV_W'(2) : cfg.div;
                state_n    = ST_DRAIN;
            end
            // direct mode has no pulse to wait for, so it drains in one cycle
            if (state == ST_DRAIN && (M || wrap)) begin
                m_n     = pend_m;
                div_n   = pend_div;
                cnt_n   = '0;
                scnt_n  = '0;
                state_n = ST_SETTLE;
            end
        end
        // pulse flop looks ahead at next-cycle count so DIV_M lines up with cnt==N-1
        div_m_n = state_n != ST_SETTLE && !m_n && cnt_n == div_n - DIV_W'(1);
    end
endmodule

// File: tb/tb_fmdll_mode_seq.sv
// tb_fmdll_mode_seq: directed stimulus with a cycle-level reference model and literal timing checks
module tb_fmdll_mode_seq;
    localparam int DIV_W  = 4;
    localparam int SETTLE = 8;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             M, DIV_M, busy;
    logic [DIV_W-1:0] cur_div;
    int               n_pass = 0, n_total = 0, cyc = 0, ticks = 0, first_ready = -1;
    int               phase = 0, sidx = 0, age = 0, em = 1, en = 2, pm = 1, pn = 2;
    int               a, p0, p1, p2;
    fmdll_mode_seq_if #(.DIV_W(DIV_W)) cfg ();
    fmdll_mode_seq #(.DIV_W(DIV_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .cfg(cfg), .M(M), .DIV_M(DIV_M), .cur_div(cur_div), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    endtask
    // Model: phase 0 = settling, 1 = running, 2 = draining; age counts cycles since RUN began
    always @(posedge clk) begin
        ticks++;
        if (rst) begin
            phase = 0; sidx = 0; age = 0; em = 1; en = 2; cyc = 0;
        end else begin
            cyc++;
            if (phase == 0) begin
                if (sidx == SETTLE - 1) begin phase = 1; age = 0; end
                else sidx++;
            end else if (phase == 1) begin
                if (cfg.valid) begin pm = cfg.m; pn = cfg.div < 2 ? 2 : int'(cfg.div); phase = 2; end
                age++;
            end else if (em == 1 || age % en == en - 1) begin
                em = pm; en = pn; phase = 0; sidx = 0;
            end else age++;
        end
    end
    always @(negedge clk) begin
        if (ticks > 0) begin
            chk("M", int'(M), em);
            chk("cur_div", int'(cur_div), en);
            chk("busy", int'(busy), int'(phase != 1));
            chk("cfg_ready", int'(cfg.ready), int'(phase == 1));
            chk("DIV_M", int'(DIV_M), int'(phase != 0 && em == 0 && age % en == en - 1));
            if (!rst && cfg.ready && first_ready < 0) first_ready = cyc;
        end
    end
    task automatic wait_pulse(output int c);
        c = -1;
        for (int i = 0; i < 64 && c < 0; i++) begin
            @(negedge clk);
            if (DIV_M) c = cyc;
        end
        if (c < 0) chk("pulse_timeout", 0, 1);
    endtask
    task automatic wait_ready();
        for (int i = 0; i < 64 && !cfg.ready; i++) @(negedge clk);
        if (!cfg.ready) chk("ready_timeout", 0, 1);
    endtask
    task automatic req(input logic m, input logic [DIV_W-1:0] d, output int acc);
        cfg.valid = 1'b1; cfg.m = m; cfg.div = d;
        wait_ready();
        acc = cyc;
        @(negedge clk);
        cfg.valid = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        cfg.valid = 1'b0; cfg.m = 1'b1; cfg.div = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        chk("first_ready_cycle", first_ready, SETTLE);
        req(1'b0, 4'd4, a);
        wait_pulse(p1);
        chk("latency_m1_to_n4", p1 - a, 1 + SETTLE + 4);
        wait_pulse(p2);
        chk("period_n4", p2 - p1, 4);
        repeat (2) @(negedge clk);
        req(1'b0, 4'd3, a);
        wait_pulse(p0);
        chk("old_pulse_in_drain", p0 - a, 2);
        wait_pulse(p1);
        chk("latency_n4_to_n3", p1 - a, 2 + SETTLE + 3);
        wait_pulse(p2);
        chk("period_n3", p2 - p1, 3);
        req(1'b0, 4'd0, a);
        wait_ready();
        chk("clamp_div0", int'(cur_div), 2);
        wait_pulse(p1); wait_pulse(p2);
        chk("period_div0", p2 - p1, 2);
        req(1'b0, 4'd1, a);
        wait_ready();
        chk("clamp_div1", int'(cur_div), 2);
        wait_pulse(p1); wait_pulse(p2);
        chk("period_div1", p2 - p1, 2);
        cfg.valid = 1'b1; cfg.m = 1'b0; cfg.div = 4'd5;
        @(negedge clk);
        cfg.div = 4'd6;
        chk("held_first_accept_busy", int'(busy), 1);
        wait_ready();
        chk("held_applied_first", int'(cur_div), 5);
        @(negedge clk);
        cfg.valid = 1'b0;
        chk("held_second_accept_busy", int'(busy), 1);
        wait_ready();
        chk("held_applied_second", int'(cur_div), 6);
        wait_pulse(p1); wait_pulse(p2);
        chk("period_n6", p2 - p1, 6);
        req(1'b0, 4'd5, a);
        chk("drain_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_M", int'(M), 1);
        chk("rst_cur_div", int'(cur_div), 2);
        chk("rst_DIV_M", int'(DIV_M), 0);
        wait_ready();
        repeat (10) @(negedge clk);
        chk("pending_discarded_div", int'(cur_div), 2);
        chk("pending_discarded_M", int'(M), 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
